// File: rtl/spi_flash_cmd_ctrl.sv
// SPI flash command controller: issues RDID (0x9F, 24 data bits) or RDSR (0x05, 8 data bits)
// in SPI mode 0 and returns the shifted-in result on data_out with a one-cycle done pulse.
module spi_flash_cmd_ctrl #(
   parameter int CLK_DIV = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_rdid,
   input  logic        req_rdsr,
   input  logic        miso,
   output logic        cs_n,
   output logic        sck,
   output logic        mosi,
   output logic [23:0] data_out,
   output logic        done_rdid,
   output logic        done_rdsr,
   output logic        busy
);

   // state       | meaning
   // IDLE        | waiting for a request, arbitrating between RDID and RDSR
   // ASSERT_CS   | cs_n low, sck low, mosi = instruction bit 7, CLK_DIV cycles
   // SEND_INST   | shifting out the 8 instruction bits, MSB first
   // GET_DATA    | shifting in 24 (RDID) or 8 (RDSR) bits from miso
   // DEASSERT_CS | cs_n high for CLK_DIV cycles before returning to IDLE
   typedef enum logic [2:0] {
      IDLE,
      ASSERT_CS,
      SEND_INST,
      GET_DATA,
      DEASSERT_CS
   } state_t;

   localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);

   state_t      state;
   logic [7:0]  div_cnt;
   logic [5:0]  bit_cnt;
   logic [7:0]  inst;
   logic [23:0] shreg;
   logic        last_grant;   // 1 = RDID was granted last, 0 = RDSR
   logic        cur_rdid;
   logic        grant_any;
   logic        grant_rdid;
   logic [7:0]  inst_sel;

   always_comb begin
      grant_any  = (req_rdid || req_rdsr) && !done_rdid && !done_rdsr;
      grant_rdid = req_rdid && (!req_rdsr || !last_grant);
      inst_sel   = grant_rdid ? 8'h9F : 8'h05;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cs_n       <= 1'b1;
         sck        <= 1'b0;
         mosi       <= 1'b0;
         data_out   <= 24'h0;
         done_rdid  <= 1'b0;
         done_rdsr  <= 1'b0;
         busy       <= 1'b0;
         last_grant <= 1'b0;
         cur_rdid   <= 1'b0;
         div_cnt    <= 8'h0;
         bit_cnt    <= 6'h0;
         inst       <= 8'h0;
         shreg      <= 24'h0;
      end else begin
         done_rdid <= 1'b0;
         done_rdsr <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_any) begin
                  state      <= ASSERT_CS;
                  busy       <= 1'b1;
                  cs_n       <= 1'b0;
                  sck        <= 1'b0;
                  cur_rdid   <= grant_rdid;
                  last_grant <= grant_rdid;
                  inst       <= inst_sel;
                  mosi       <= inst_sel[7];
                  shreg      <= 24'h0;
                  div_cnt    <= DIV_LOAD;
               end
            end
            ASSERT_CS: begin
               if (div_cnt == 8'h0) begin
                  state   <= SEND_INST;
                  div_cnt <= DIV_LOAD;
                  bit_cnt <= 6'd7;
               end else begin
                  div_cnt <= div_cnt - 8'h1;
               end
            end
            SEND_INST: begin
               if (div_cnt != 8'h0) begin
                  div_cnt <= div_cnt - 8'h1;
               end else begin
                  div_cnt <= DIV_LOAD;
                  if (!sck) begin
                     sck <= 1'b1;
                  end else begin
                     sck <= 1'b0;
                     if (bit_cnt == 6'h0) begin
                        state   <= GET_DATA;
                        mosi    <= 1'b0;
                        bit_cnt <= cur_rdid ? 6'd23 : 6'd7;
                     end else begin
                        bit_cnt <= bit_cnt - 6'h1;
                        inst    <= {inst[6:0], 1'b0};
                        mosi    <= inst[6];
                     end
                  end
               end
            end
            GET_DATA: begin
               if (div_cnt != 8'h0) begin
                  div_cnt <= div_cnt - 8'h1;
               end else begin
                  div_cnt <= DIV_LOAD;
                  if (!sck) begin
                     sck   <= 1'b1;
                     shreg <= {shreg[22:0], miso};
                  end else begin
                     sck <= 1'b0;
                     if (bit_cnt == 6'h0) begin
                        state <= DEASSERT_CS;
                        cs_n  <= 1'b1;
                     end else begin
                        bit_cnt <= bit_cnt - 6'h1;
                     end
                  end
               end
            end
            DEASSERT_CS: begin
               if (div_cnt == 8'h0) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  data_out  <= shreg;
                  done_rdid <= cur_rdid;
                  done_rdsr <= !cur_rdid;
               end else begin
                  div_cnt <= div_cnt - 8'h1;
               end
            end
            default: begin
               state <= IDLE;
               cs_n  <= 1'b1;
               sck   <= 1'b0;
               mosi  <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_flash_cmd_ctrl.sv
// Bench for spi_flash_cmd_ctrl: two instances (CLK_DIV=2 and CLK_DIV=1) talking to a behavioural
// flash model; transactions are checked against frame-length, instruction and arbitration rules.
module tb_spi_flash_cmd_ctrl;

   logic        clk = 1'b0;
   logic        rst       [2];
   logic        req_rdid  [2];
   logic        req_rdsr  [2];
   logic        miso      [2];
   logic        cs_n      [2];
   logic        sck       [2];
   logic        mosi      [2];
   logic [23:0] data_out  [2];
   logic        done_rdid [2];
   logic        done_rdsr [2];
   logic        busy      [2];

   // flash-side model state and monitor tallies
   logic [23:0] id_val    [2];
   logic [7:0]  sr_val    [2];
   logic [7:0]  inst_cap  [2];
   logic [7:0]  last_inst [2];
   int          low_cnt   [2];
   int          last_low  [2];
   int          bcnt      [2];
   int          hi_run    [2];
   int          sck_bad   [2];
   int          mosi_bad  [2];
   int          nd_id     [2];
   int          nd_sr     [2];
   int          dbl       [2];
   logic        prev_cs   [2];
   logic        prev_sck  [2];
   logic        prev_mosi [2];
   logic        prev_done [2];

   bit          last_grant_m [2];   // 1 = RDID served last
   int          total  = 0;
   int          passed = 0;

   always #5 clk = ~clk;

   spi_flash_cmd_ctrl #(.CLK_DIV(2)) dut (
      .clk(clk), .reset(rst[0]), .req_rdid(req_rdid[0]), .req_rdsr(req_rdsr[0]), .miso(miso[0]),
      .cs_n(cs_n[0]), .sck(sck[0]), .mosi(mosi[0]), .data_out(data_out[0]),
      .done_rdid(done_rdid[0]), .done_rdsr(done_rdsr[0]), .busy(busy[0]));

   spi_flash_cmd_ctrl #(.CLK_DIV(1)) dut1 (
      .clk(clk), .reset(rst[1]), .req_rdid(req_rdid[1]), .req_rdsr(req_rdsr[1]), .miso(miso[1]),
      .cs_n(cs_n[1]), .sck(sck[1]), .mosi(mosi[1]), .data_out(data_out[1]),
      .done_rdid(done_rdid[1]), .done_rdsr(done_rdsr[1]), .busy(busy[1]));

   function automatic int divv(input int i);
      return (i == 0) ? 2 : 1;
   endfunction

   initial begin
      for (int i = 0; i < 2; i++) begin
         miso[i] = 1'b0; low_cnt[i] = 0; last_low[i] = 0; bcnt[i] = 0; hi_run[i] = 0;
         sck_bad[i] = 0; mosi_bad[i] = 0; nd_id[i] = 0; nd_sr[i] = 0; dbl[i] = 0;
         inst_cap[i] = 8'h0; last_inst[i] = 8'h0;
         prev_cs[i] = 1'b1; prev_sck[i] = 1'b0; prev_mosi[i] = 1'b0; prev_done[i] = 1'b0;
      end
   end

   // Mode-0 flash: captures mosi on sck rise, presents response bits after each sck fall.
   always @(negedge clk) begin
      int          n;
      int          d;
      logic [23:0] r;
      logic [4:0]  idx;
      for (int i = 0; i < 2; i++) begin
         if (!cs_n[i]) begin
            if (prev_cs[i]) begin
               low_cnt[i] = 0; bcnt[i] = 0; inst_cap[i] = 8'h0;
            end
            low_cnt[i]++;
         end else if (!prev_cs[i]) begin
            last_low[i]  = low_cnt[i];
            last_inst[i] = inst_cap[i];
         end
         if (sck[i] && !prev_sck[i]) begin
            if (bcnt[i] < 8) inst_cap[i] = {inst_cap[i][6:0], mosi[i]};
            bcnt[i]++;
            hi_run[i] = 0;
         end
         if (sck[i]) begin
            hi_run[i]++;
            if (mosi[i] !== prev_mosi[i]) mosi_bad[i]++;
         end
         if (!sck[i] && prev_sck[i]) begin
            if (hi_run[i] != divv(i)) sck_bad[i]++;
            if (bcnt[i] >= 8) begin
               n = (inst_cap[i] == 8'h9F) ? 24 : 8;
               r = (inst_cap[i] == 8'h9F) ? id_val[i] : {16'h0, sr_val[i]};
               d = bcnt[i] - 8;
               if (d < n) begin
                  idx = 5'(n - 1 - d);
                  miso[i] = r[idx];
               end else begin
                  miso[i] = 1'b0;
               end
            end
         end
         if (done_rdid[i]) nd_id[i]++;
         if (done_rdsr[i]) nd_sr[i]++;
         if ((done_rdid[i] || done_rdsr[i]) && prev_done[i]) dbl[i]++;
         prev_done[i] = done_rdid[i] || done_rdsr[i];
         prev_cs[i]   = cs_n[i];
         prev_sck[i]  = sck[i];
         prev_mosi[i] = mosi[i];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic reset_inst(input int i);
      rst[i] = 1'b1;
      tick();
      tick();
      rst[i] = 1'b0;
      last_grant_m[i] = 1'b0;
      chk("rst_cs_n", 32'(cs_n[i]), 1);
      chk("rst_sck", 32'(sck[i]), 0);
      chk("rst_mosi", 32'(mosi[i]), 0);
      chk("rst_data", 32'(data_out[i]), 0);
      chk("rst_busy", 32'(busy[i]), 0);
      chk("rst_done", 32'({done_rdid[i], done_rdsr[i]}), 0);
   endtask

   task automatic wait_done(input int i, input int drop_after, output bit got, output bit kind);
      got = 1'b0;
      kind = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         tick();
         if (c == drop_after) begin
            req_rdid[i] = 1'b0;
            req_rdsr[i] = 1'b0;
         end
         if (done_rdid[i] || done_rdsr[i]) begin
            got = 1'b1;
            kind = done_rdid[i];
            break;
         end
      end
   endtask

   // Single request, optionally dropped mid-frame; checks the whole frame against the rules.
   task automatic do_txn(input int i, input bit rdid, input int drop_after);
      bit          got, kind;
      int          n, sb0, mb0, ni0, ns0, db0;
      logic [23:0] exp;
      n   = rdid ? 24 : 8;
      exp = rdid ? id_val[i] : {16'h0, sr_val[i]};
      sb0 = sck_bad[i]; mb0 = mosi_bad[i]; ni0 = nd_id[i]; ns0 = nd_sr[i]; db0 = dbl[i];
      if (rdid) req_rdid[i] = 1'b1;
      else      req_rdsr[i] = 1'b1;
      wait_done(i, drop_after, got, kind);
      req_rdid[i] = 1'b0;
      req_rdsr[i] = 1'b0;
      chk("done_seen", 32'(got), 1);
      chk("done_kind", 32'(kind), 32'(rdid));
      chk("data_out", 32'(data_out[i]), 32'(exp));
      chk("cs_low_len", 32'(last_low[i]), 32'(divv(i) + (8 + n) * 2 * divv(i)));
      chk("inst", 32'(last_inst[i]), rdid ? 32'h9F : 32'h05);
      chk("sck_high_width", 32'(sck_bad[i] - sb0), 0);
      chk("mosi_stable_high", 32'(mosi_bad[i] - mb0), 0);
      tick();
      chk("done_rdid_count", 32'(nd_id[i] - ni0), rdid ? 1 : 0);
      chk("done_rdsr_count", 32'(nd_sr[i] - ns0), rdid ? 0 : 1);
      chk("done_single", 32'(dbl[i] - db0), 0);
      chk("idle_after", 32'({busy[i], cs_n[i], sck[i]}), 32'b010);
      last_grant_m[i] = rdid;
   endtask

   initial begin
      bit got, kind, exp_rdid;
      int ni0, ns0;
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b0; req_rdid[i] = 1'b0; req_rdsr[i] = 1'b0;
         id_val[i] = 24'h0; sr_val[i] = 8'h0; last_grant_m[i] = 1'b0;
      end
      tick();
      reset_inst(0);
      reset_inst(1);

      id_val[0] = 24'h20BA19;
      do_txn(0, 1'b1, -1);
      sr_val[0] = 8'h02;
      do_txn(0, 1'b0, -1);
      chk("data_hold", 32'(data_out[0]), 32'h000002);

      // randomized frames, some with the request dropped mid-transaction
      for (int t = 0; t < 8; t++) begin
         id_val[0] = 24'($urandom);
         sr_val[0] = 8'($urandom);
         do_txn(0, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 100)) : -1);
      end

      // tie after reset, then both held: grants alternate
      reset_inst(0);
      id_val[0] = 24'($urandom);
      sr_val[0] = 8'($urandom);
      req_rdid[0] = 1'b1;
      req_rdsr[0] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         exp_rdid = !last_grant_m[0];
         wait_done(0, -1, got, kind);
         chk("tie_done_seen", 32'(got), 1);
         chk("tie_grant", 32'(kind), 32'(exp_rdid));
         chk("tie_data", 32'(data_out[0]), exp_rdid ? 32'(id_val[0]) : 32'(sr_val[0]));
         last_grant_m[0] = exp_rdid;
         if (k == 1) req_rdsr[0] = 1'b0;
      end
      req_rdid[0] = 1'b0;
      tick();
      tick();

      // reset while shifting data bit 10 of an RDID frame
      reset_inst(0);
      id_val[0] = 24'($urandom);
      req_rdid[0] = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         tick();
         if (bcnt[0] == 19 && !cs_n[0]) begin
            got = 1'b1;
            break;
         end
      end
      chk("reach_bit10", 32'(got), 1);
      ni0 = nd_id[0];
      ns0 = nd_sr[0];
      rst[0] = 1'b1;
      req_rdid[0] = 1'b0;
      tick();
      rst[0] = 1'b0;
      last_grant_m[0] = 1'b0;
      chk("midrst_cs_n", 32'(cs_n[0]), 1);
      chk("midrst_sck", 32'(sck[0]), 0);
      chk("midrst_busy", 32'(busy[0]), 0);
      chk("midrst_data", 32'(data_out[0]), 0);
      for (int c = 0; c < 30; c++) tick();
      chk("midrst_no_done", 32'((nd_id[0] - ni0) + (nd_sr[0] - ns0)), 0);
      do_txn(0, 1'b1, -1);

      // CLK_DIV = 1 instance
      id_val[1] = 24'($urandom);
      sr_val[1] = 8'($urandom);
      do_txn(1, 1'b1, -1);
      do_txn(1, 1'b0, -1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
